uart_rx_packer: RTL and testbench

UART_RX_PACKER -- requirements
Module: uart_rx_packer

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_byte.sv | 125 ++++++++++++
 rtl/uart_rx_packer.sv | 85 ++++++++
 tb/tb_uart_rx_packer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive/pack path.
package uart_pkg;

  typedef enum logic [1:0] {
    S_RX_IDLE,
    S_RX_START,
    S_RX_DATA,
    S_RX_STOP
  } rx_state_t;

  // Clock cycles per serial bit (integer division).
  function automatic int unsigned clks_per_bit(input int unsigned freq_hz,
                                               input int unsigned baud);
    return freq_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 serial byte receiver: synchronizer, falling-edge start detect and
// mid-bit sampling; emits one-cycle rx_valid / rx_frame_err pulses.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       enable,
  input  logic       restart,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned HALF_LAST_I = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_LAST_I);

  logic [1:0]       sync;
  logic             rx_prev;
  logic             rx_s;
  rx_state_t        state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       bit_idx, bit_d;
  logic [7:0]       shreg, shreg_d;
  logic [7:0]       data_d;
  logic             valid_d, ferr_d;

  assign rx_s = sync[1];

  // Synchronizer plus one extra stage for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      sync    <= {sync[0], rx};
      rx_prev <= sync[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_RX_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      bit_idx      <= bit_d;
      shreg        <= shreg_d;
      rx_data      <= data_d;
      rx_valid     <= valid_d;
      rx_frame_err <= ferr_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    bit_d   = bit_idx;
    shreg_d = shreg;
    data_d  = rx_data;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state)
      S_RX_IDLE: begin
        if (enable && rx_prev && !rx_s) begin
          state_d = S_RX_START;
          cnt_d   = '0;
        end
      end
      S_RX_START: begin
        // A start bit that is high again at mid-bit was a glitch.
        if (cnt == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? S_RX_IDLE : S_RX_DATA;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_RX_DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg[7:1]};
          bit_d   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_d = S_RX_STOP;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_RX_STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_RX_IDLE;
          if (rx_s) begin
            data_d  = shreg;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: state_d = S_RX_IDLE;
    endcase
    if (restart) begin
      state_d = S_RX_IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_packer.sv
// Receives UART bytes, packs pairs big-endian into 16-bit words and writes
// them to sequential SRAM addresses for one load session.
module uart_rx_packer
  import uart_pkg::*;
#(
  parameter int unsigned C_S_AXI_ACLK_FREQ_HZ = 100000000,
  parameter int unsigned C_BAUDRATE           = 9600,
  parameter int unsigned MEMORY_ADDR_WIDTH    = 18,
  parameter int unsigned MEMORY_DATA_WIDTH    = 16,
  parameter int unsigned NUM_WORDS            = 2**18
) (
  input  logic                         S_AXI_ACLK,
  input  logic                         S_AXI_ARESETN,
  input  logic                         UART_RX_I,
  input  logic                         Initialize,
  output logic                         Enable,
  output logic [MEMORY_ADDR_WIDTH-1:0] SRAM_address,
  output logic [MEMORY_DATA_WIDTH-1:0] SRAM_write_data,
  output logic                         SRAM_we_n,
  output logic                         Frame_error
);

  localparam int unsigned CPB = clks_per_bit(C_S_AXI_ACLK_FREQ_HZ, C_BAUDRATE);
  localparam logic [MEMORY_ADDR_WIDTH-1:0] LAST_ADDR = MEMORY_ADDR_WIDTH'(NUM_WORDS - 1);

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic [7:0] hi_byte;
  logic       phase;
  logic       byte_take;

  uart_rx_byte #(
    .CLKS_PER_BIT(CPB)
  ) u_rx (
    .clk         (S_AXI_ACLK),
    .rst_n       (S_AXI_ARESETN),
    .rx          (UART_RX_I),
    .enable      (Enable),
    .restart     (Initialize),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err)
  );

  // Bytes only count inside an active session; a pending lone byte dies with it.
  assign byte_take = rx_valid & Enable & ~Initialize;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      Enable          <= 1'b0;
      SRAM_address    <= '0;
      SRAM_write_data <= '0;
      SRAM_we_n       <= 1'b1;
      Frame_error     <= 1'b0;
      hi_byte         <= '0;
      phase           <= 1'b0;
    end else begin
      SRAM_we_n <= 1'b1;
      if (byte_take) begin
        if (phase) begin
          SRAM_write_data <= MEMORY_DATA_WIDTH'({hi_byte, rx_data});
          SRAM_we_n       <= 1'b0;
          phase           <= 1'b0;
        end else begin
          hi_byte <= rx_data;
          phase   <= 1'b1;
        end
      end
      if (rx_frame_err && Enable) Frame_error <= 1'b1;
      // Address advances after the strobe; the final word ends the session.
      if (!SRAM_we_n) begin
        if (SRAM_address == LAST_ADDR) Enable <= 1'b0;
        else SRAM_address <= SRAM_address + MEMORY_ADDR_WIDTH'(1);
      end
      if (Initialize) begin
        SRAM_address <= '0;
        phase        <= 1'b0;
        Frame_error  <= 1'b0;
        Enable       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_packer.sv
// Scoreboard bench for uart_rx_packer: serial frames in, expected SRAM writes
// queued by a byte-level session model, a monitor checks every strobe.
module tb_uart_rx_packer;

  localparam int unsigned CPB = 16;
  localparam int unsigned NW  = 4;
  localparam int unsigned AW  = 18;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic          init = 1'b0;
  logic          en;
  logic [AW-1:0] addr;
  logic [15:0]   wdata;
  logic          we_n;
  logic          ferr;

  int n_checks = 0;
  int n_pass   = 0;

  logic [AW+15:0] exp_q[$];

  // Session model: words written, pending first byte, sticky error.
  bit         m_session = 0;
  int         m_written = 0;
  bit         m_have_hi = 0;
  logic [7:0] m_hi = '0;
  bit         m_ferr = 0;

  uart_rx_packer #(
    .C_S_AXI_ACLK_FREQ_HZ(16),
    .C_BAUDRATE          (1),
    .MEMORY_ADDR_WIDTH   (AW),
    .MEMORY_DATA_WIDTH   (16),
    .NUM_WORDS           (NW)
  ) dut (
    .S_AXI_ACLK     (clk),
    .S_AXI_ARESETN  (rst_n),
    .UART_RX_I      (rx),
    .Initialize     (init),
    .Enable         (en),
    .SRAM_address   (addr),
    .SRAM_write_data(wdata),
    .SRAM_we_n      (we_n),
    .Frame_error    (ferr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  function automatic bit m_enabled();
    return m_session && (m_written < int'(NW));
  endfunction

  function automatic int m_addr();
    return (m_written < int'(NW)) ? m_written : int'(NW) - 1;
  endfunction

  function automatic void model_init();
    m_session = 1; m_written = 0; m_have_hi = 0; m_ferr = 0;
  endfunction

  function automatic void model_reset();
    m_session = 0; m_written = 0; m_have_hi = 0; m_ferr = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b, input bit good);
    if (!m_enabled()) return;
    if (!good) begin
      m_ferr = 1;
      return;
    end
    if (!m_have_hi) begin
      m_hi = b;
      m_have_hi = 1;
    end else begin
      exp_q.push_back({AW'(m_written), m_hi, b});
      m_written++;
      m_have_hi = 0;
    end
  endfunction

  // One write per strobe cycle; anything not predicted is an error.
  always @(negedge clk) begin : monitor
    logic [AW+15:0] e;
    if (rst_n && we_n === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_strobe: got addr=%0d data=0x%h, want no write", addr, wdata);
      end else begin
        e = exp_q.pop_front();
        check("strobe_addr_data", 64'({addr, wdata}), 64'(e));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit good, input bit track);
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    if (track) model_byte(b, good);
    rx = good;
    repeat (CPB) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic init_pulse();
    @(negedge clk);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    model_init();
  endtask

  task automatic check_status(input string tag);
    @(negedge clk);
    check({tag, "_enable"}, 64'(en), 64'(m_enabled()));
    check({tag, "_address"}, 64'(addr), 64'(m_addr()));
    check({tag, "_frame_error"}, 64'(ferr), 64'(m_ferr));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_enable"}, 64'(en), 64'(0));
    check({tag, "_address"}, 64'(addr), 64'(0));
    check({tag, "_wdata"}, 64'(wdata), 64'(0));
    check({tag, "_we_n"}, 64'(we_n), 64'(1));
    check({tag, "_frame_error"}, 64'(ferr), 64'(0));
  endtask

  initial begin
    logic [7:0] b0, b1;
    bit seen;
    bit good;

    // Reset state, then release without a session.
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    send_byte(8'h5A, 1, 1);
    send_byte(8'hC3, 1, 1);
    check_status("no_session");

    // Single pair.
    init_pulse();
    send_byte(8'hA5, 1, 1);
    send_byte(8'h3C, 1, 1);
    check_status("pair");

    // Fill all words; extra byte is ignored.
    init_pulse();
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1, 1);
    check_status("full");
    send_byte(8'h09, 1, 1);
    check_status("after_full");

    // Framing error drops a byte without disturbing pairing.
    init_pulse();
    send_byte(8'h11, 1, 1);
    send_byte(8'h22, 0, 1);
    send_byte(8'h33, 1, 1);
    check_status("frame_err");

    // Short low glitch on the line.
    init_pulse();
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (40) @(posedge clk);
    check_status("glitch");
    send_byte(8'h5A, 1, 1);
    send_byte(8'hC3, 1, 1);
    check_status("after_glitch");

    // Initialize coinciding with the strobe for address 2.
    init_pulse();
    for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)), 1, 1);
    b0 = 8'($urandom_range(0, 255));
    b1 = 8'($urandom_range(0, 255));
    seen = 0;
    fork
      begin
        send_byte(b0, 1, 1);
        send_byte(b1, 1, 1);
      end
      begin
        for (int c = 0; c < 600 && !seen; c++) begin
          @(negedge clk);
          if (we_n === 1'b0) seen = 1;
        end
        if (!seen) begin
          n_checks++;
          $display("FAIL init_on_strobe_wait: got no strobe within 600 cycles, want one");
        end else begin
          init = 1'b1;
          @(negedge clk);
          init = 1'b0;
          check("init_on_strobe_address", 64'(addr), 64'(0));
          check("init_on_strobe_enable", 64'(en), 64'(1));
          model_init();
        end
      end
    join
    check_status("after_init_strobe");

    // Randomized session with occasional bad stop bits.
    init_pulse();
    for (int i = 0; i < 14; i++) begin
      good = ($urandom_range(0, 4) != 0);
      send_byte(8'($urandom_range(0, 255)), good, 1);
      check_status("random");
    end

    // Asynchronous reset in the middle of a data bit.
    init_pulse();
    send_byte(8'h7E, 1, 1);
    send_byte(8'h81, 1, 1);
    send_byte(8'h44, 0, 1);
    check_status("pre_reset");
    fork
      send_byte(8'h96, 1, 0);
      begin
        repeat (60) @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("mid_reset");
      end
    join
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h12, 1, 1);
    send_byte(8'h34, 1, 1);
    check_status("post_reset");

    repeat (10) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
